// File: rtl/logic_op_pipe.sv
// Registered AND/OR/NOR/INV stage with valid/ready on both sides.
// A main output register plus one skid entry sustain full throughput under backpressure.
module logic_op_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             ZERO,
  output logic [1:0]       OUT_OP
);

  // Encoding mirrors {main valid, skid valid}, so bit 1 is OUT_VALID directly.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] skid_y_q, skid_y_d;
  logic             skid_zero_q, skid_zero_d;
  logic [1:0]       skid_op_q, skid_op_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH-1:0] func_res;
  logic             func_zero;
  logic             accept;
  logic             emit;

  // INV uses only A so an unknown B can never reach the result.
  always_comb begin
    func_res = '0;
    case (OP)
      2'b00:   func_res = A & B;
      2'b01:   func_res = A | B;
      2'b10:   func_res = ~(A | B);
      default: func_res = ~A;
    endcase
  end

  assign func_zero = ~|func_res;
  assign accept    = IN_VALID & in_ready_q;
  assign emit      = state_q[1] & OUT_READY;

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    zero_d      = zero_q;
    op_d        = op_q;
    skid_y_d    = skid_y_q;
    skid_zero_d = skid_zero_q;
    skid_op_d   = skid_op_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          y_d     = func_res;
          zero_d  = func_zero;
          op_d    = OP;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          y_d    = func_res;
          zero_d = func_zero;
          op_d   = OP;
        end else if (accept) begin
          skid_y_d    = func_res;
          skid_zero_d = func_zero;
          skid_op_d   = OP;
          state_d     = FULL;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          y_d     = skid_y_q;
          zero_d  = skid_zero_q;
          op_d    = skid_op_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      y_q         <= '0;
      zero_q      <= 1'b0;
      op_q        <= 2'b00;
      skid_y_q    <= '0;
      skid_zero_q <= 1'b0;
      skid_op_q   <= 2'b00;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      op_q        <= op_d;
      skid_y_q    <= skid_y_d;
      skid_zero_q <= skid_zero_d;
      skid_op_q   <= skid_op_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign OUT_VALID = state_q[1];
  assign IN_READY  = in_ready_q;
  assign Y         = y_q;
  assign ZERO      = zero_q;
  assign OUT_OP    = op_q;

endmodule
